riscv_run_dump_ctrl: RTL
========================

Name: riscv_run_dump_ctrl

Overview:
Synthesizable end-of-run controller for the RISC-V CPU cores. It gates the core's run enable for a bounded cycle budget or until the core signals halt. It then walks the register file through a read port and streams every register out on a valid/ready channel. It replaces fixed-length simulation-only dumps with a parametrised, reusable block usable in simulation and on FPGA.

Parameters:
XLEN, 32, register data width.
NREGS, 32, number of architectural registers dumped (power of two, >=2).
TIMEOUT_CYCLES, 100, maximum run cycles before forced stop (>=1).
CNT_W, 16, cycle counter width; TIMEOUT_CYCLES must be < 2**CNT_W.

Ports:
clock  in  1  single system clock, rising edge.
reset_n  in  1  asynchronous active-low reset.
start  in  1  one-cycle pulse; begins a run (honoured in IDLE or DONE only).
halt_req  in  1  core reports halt (ebreak/ecall); level, sampled in RUN.
cpu_run  out  1  run enable to the core; high only in RUN.
rf_raddr  out  $clog2(NREGS)  register file read address.
rf_rdata  in  XLEN  register file read data; valid one cycle after rf_raddr.
dump_valid  out  1  dump beat valid.
dump_ready  in  1  downstream ready.
dump_idx  out  $clog2(NREGS)+1  register index of current beat.
dump_data  out  XLEN  register value of current beat.
run_cycles  out  CNT_W  cycles spent in RUN for the last or current run.
busy  out  1  high in RUN, READ, SEND.
done  out  1  high in DONE.
timed_out  out  1  last run ended by budget exhaustion, not halt_req.

Behaviour:
- Reset (async assert, sync deassert): state=IDLE. All outputs 0: cpu_run, dump_valid, busy, done, timed_out, rf_raddr, dump_idx, dump_data, run_cycles. Reset mid-run or mid-dump aborts immediately with no partial beat.
- States: IDLE, RUN, READ, SEND, DONE.
- IDLE/DONE: start -> RUN. On entry run_cycles=0, timed_out=0, idx=0. done drops the cycle after start.
- RUN: cpu_run=1; run_cycles increments each cycle.
  - halt_req=1 -> READ, timed_out=0.
  - Else if run_cycles==TIMEOUT_CYCLES-1 -> READ, timed_out=1.
  - If halt_req and timeout coincide, halt wins (timed_out=0).
  - Exactly TIMEOUT_CYCLES cycles of cpu_run at most. run_cycles freezes on exit.
- READ: rf_raddr=idx. Next cycle -> SEND, capturing dump_data=rf_rdata and dump_idx=idx.
- SEND: dump_valid=1. dump_data/dump_idx stay stable until handshake (dump_valid & dump_ready).
  - On handshake: if idx==NREGS-1 -> DONE (or CSUM, see Optional Feature), else idx+1 -> READ.
  - Throughput is one beat per 2 cycles at full ready; dump_valid never asserts in back-to-back cycles.
- start outside IDLE/DONE is ignored. halt_req outside RUN is ignored.
- Width rules: idx wraps never (terminal check at NREGS-1). run_cycles saturates at 2**CNT_W-1 (unreachable under the parameter rule; assert in simulation).

Optional Feature:
Macro DUMP_CHECKSUM_EN.
- Defined: adds state CSUM after the last register handshake. Emits one extra beat with dump_idx=NREGS and dump_data = sum of all dumped values mod 2**XLEN. The running sum is cleared on start and accumulated at each register handshake. CSUM -> DONE on its handshake.
- Undefined: no CSUM state, no accumulator; the last register handshake goes straight to DONE. dump_idx MSB is always 0.

Decomposition:
- Shared package riscv_dbg_pkg:
  - state enum (IDLE, RUN, READ, SEND, DONE, CSUM).
  - localparam IDX_W = $clog2(NREGS)+1.
  - beat struct {idx, data}.
- One natural sub-module: riscv_dump_beat_reg, a valid/ready holding register for dump_idx/dump_data with a stall-stable guarantee, reused by other debug streamers.

Test Plan:
- halt_req asserted on cycle 10 of RUN, regs x[i]=i*3, ready tied 1 -> cpu_run high 10 cycles, run_cycles=10, timed_out=0. 32 beats with idx 0..31, data 0,3,...,93, then done=1.
- halt_req never asserted, TIMEOUT_CYCLES=100 -> cpu_run high exactly 100 cycles, timed_out=1, run_cycles=99 frozen, full dump follows.
- Random dump_ready (50%) -> no beat lost or duplicated. dump_data/dump_idx unchanged while valid & !ready. Beat count=32.
- halt_req rises on the same cycle run_cycles=99 -> timed_out=0.
- reset_n pulsed low during SEND of idx 7 -> all outputs 0 immediately. A fresh start restarts at idx 0.
- DUMP_CHECKSUM_EN, regs x[i]=0xFFFF_FFFF -> 33rd beat idx=32, data=0xFFFF_FFE0. A second start with x[i]=1 yields data=32 (accumulator cleared).

Source files
------------

// File: rtl/riscv_dbg_pkg.sv
// Shared types for the RISC-V debug/dump streamers: controller states and beat layout.
// The CSUM state is only reachable when DUMP_CHECKSUM_EN is defined.
package riscv_dbg_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RUN  = 3'd1,
      READ = 3'd2,
      SEND = 3'd3,
      DONE = 3'd4,
      CSUM = 3'd5
   } state_t;

   localparam int NREGS_DEF = 32;
   localparam int XLEN_DEF  = 32;

   // One extra index bit leaves room for the checksum beat at idx == NREGS.
   function automatic int idx_width(input int nregs);
      return $clog2(nregs) + 1;
   endfunction

   localparam int IDX_W = idx_width(NREGS_DEF);

   typedef struct packed {
      logic [IDX_W-1:0]    idx;
      logic [XLEN_DEF-1:0] data;
   } beat_t;

endpackage

// File: rtl/riscv_dump_beat_reg.sv
// Valid/ready holding register for one dump beat; idx/data never change while valid & !ready.
module riscv_dump_beat_reg #(
   parameter int IW = 6,
   parameter int DW = 32
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          load,
   input  logic [IW-1:0] load_idx,
   input  logic [DW-1:0] load_data,
   input  logic          ready,
   output logic          valid,
   output logic [IW-1:0] idx,
   output logic [DW-1:0] data
);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         valid <= 1'b0;
         idx   <= '0;
         data  <= '0;
      end else if (load && (!valid || ready)) begin
         valid <= 1'b1;
         idx   <= load_idx;
         data  <= load_data;
      end else if (valid && ready) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/riscv_run_dump_ctrl.sv
// End-of-run controller: gates cpu_run for a bounded budget, then streams the register file.
// Define DUMP_CHECKSUM_EN to append a modular-sum beat (idx == NREGS) after the last register.
module riscv_run_dump_ctrl
   import riscv_dbg_pkg::*;
#(
   parameter int XLEN           = 32,
   parameter int NREGS          = 32,
   parameter int TIMEOUT_CYCLES = 100,
   parameter int CNT_W          = 16
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     start,
   input  logic                     halt_req,
   output logic                     cpu_run,
   output logic [$clog2(NREGS)-1:0] rf_raddr,
   input  logic [XLEN-1:0]          rf_rdata,
   output logic                     dump_valid,
   input  logic                     dump_ready,
   output logic [$clog2(NREGS):0]   dump_idx,
   output logic [XLEN-1:0]          dump_data,
   output logic [CNT_W-1:0]         run_cycles,
   output logic                     busy,
   output logic                     done,
   output logic                     timed_out
);

   localparam int AW = $clog2(NREGS);
   localparam int IW = idx_width(NREGS);
   localparam logic [AW-1:0]    LAST  = AW'(NREGS - 1);
   localparam logic [CNT_W-1:0] TLAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t          state;
   logic [AW-1:0]   idx;
   logic            hs;
   logic            beat_load;
   logic [IW-1:0]   beat_idx;
   logic [XLEN-1:0] beat_data;
`ifdef DUMP_CHECKSUM_EN
   logic [XLEN-1:0] csum;
`endif

   assign hs = dump_valid & dump_ready;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         idx        <= '0;
         run_cycles <= '0;
         timed_out  <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
         csum       <= '0;
`endif
      end else begin
         case (state)
            IDLE, DONE: if (start) begin
               state      <= RUN;
               idx        <= '0;
               run_cycles <= '0;
               timed_out  <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
               csum       <= '0;
`endif
            end
            RUN: begin
               if (halt_req) begin
                  state     <= READ;
                  timed_out <= 1'b0;
               end else if (run_cycles == TLAST) begin
                  state     <= READ;
                  timed_out <= 1'b1;
               end
               // Counter stops at TLAST so a budget-exhausted run reports TIMEOUT_CYCLES-1.
               if (run_cycles != TLAST && run_cycles != {CNT_W{1'b1}})
                  run_cycles <= run_cycles + CNT_W'(1);
            end
            READ: state <= SEND;
            SEND: if (hs) begin
`ifdef DUMP_CHECKSUM_EN
               csum <= csum + dump_data;
               if (idx == LAST) state <= CSUM;
`else
               if (idx == LAST) state <= DONE;
`endif
               else begin
                  idx   <= idx + AW'(1);
                  state <= READ;
               end
            end
`ifdef DUMP_CHECKSUM_EN
            CSUM: if (hs) state <= DONE;
`endif
            default: state <= IDLE;
         endcase
      end
   end

   // Present the next address during the accepting SEND cycle so a registered RF has data ready in READ.
   assign rf_raddr = (state == SEND && hs) ? idx + AW'(1) : idx;

   always_comb begin
      beat_load = (state == READ);
      beat_idx  = {1'b0, idx};
      beat_data = rf_rdata;
`ifdef DUMP_CHECKSUM_EN
      if (state == CSUM) begin
         beat_load = !dump_valid;
         beat_idx  = IW'(NREGS);
         beat_data = csum;
      end
`endif
   end

   riscv_dump_beat_reg #(.IW(IW), .DW(XLEN)) u_beat (
      .clock     (clock),
      .reset_n   (reset_n),
      .load      (beat_load),
      .load_idx  (beat_idx),
      .load_data (beat_data),
      .ready     (dump_ready),
      .valid     (dump_valid),
      .idx       (dump_idx),
      .data      (dump_data)
   );

   assign cpu_run = (state == RUN);
   assign busy    = (state == RUN) || (state == READ) || (state == SEND) || (state == CSUM);
   assign done    = (state == DONE);

`ifndef SYNTHESIS
   a_run_cycles_no_sat: assert property (@(posedge clock) disable iff (!reset_n)
      run_cycles != {CNT_W{1'b1}});
`endif

endmodule
